// File: rtl/lcd_bus_responder.sv
// HD44780-style 8-bit LCD bus responder: decodes enable-strobed writes into DDRAM/CGRAM/flags.
// Define LCD_RESPONDER_READ_EN to add bus read-back (rd_bus_data/rd_bus_oe) for rw=1 strobes.
module lcd_bus_responder #(
   parameter int unsigned BUSY_CYCLES = 4,
   parameter logic [7:0]  DDRAM_RESET = 8'h20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rs,
   input  logic       rw,
   input  logic       enable,
   input  logic [7:0] data,
   input  logic [6:0] rd_addr,
   input  logic       rd_cgram,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       txn_valid,
   output logic       txn_rs,
   output logic [7:0] txn_data,
   output logic [6:0] addr_counter,
   output logic       cgram_sel,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       inc_mode,
   output logic       shift_mode,
   output logic       lines2,
   output logic       mode8,
   output logic [5:0] shift_off,
   output logic [2:0] err_flags
`ifdef LCD_RESPONDER_READ_EN
   ,
   output logic [7:0] rd_bus_data,
   output logic       rd_bus_oe
`endif
);

`ifdef LCD_RESPONDER_READ_EN
   localparam bit READ_EN = 1'b1;
`else
   localparam bit READ_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR, S_HOLD} state_e;
   typedef struct packed {logic rs; logic rw; logic [7:0] data;} bus_t;
   typedef struct packed {
      logic display_on, cursor_on, blink_on, inc_mode, shift_mode, lines2, mode8;
   } ctrl_t;

   // DDRAM line 1 is 0x00-0x27, line 2 is 0x40-0x67; flat index 0..79.
   function automatic logic dd_valid(input logic [6:0] a);
      return a[5:0] < 6'd40;
   endfunction

   function automatic logic [6:0] dd_index(input logic [6:0] a);
      return a[6] ? {1'b0, a[5:0]} + 7'd40 : {1'b0, a[5:0]};
   endfunction

   function automatic logic [6:0] dd_step(input logic [6:0] a, input logic up);
      if (up) begin
         if (a == 7'h27) return 7'h40;
         if (a == 7'h67) return 7'h00;
         return a + 7'd1;
      end
      if (a == 7'h00) return 7'h67;
      if (a == 7'h40) return 7'h27;
      return a - 7'd1;
   endfunction

   function automatic logic [6:0] ac_step(input logic [6:0] a, input logic cg, input logic up);
      logic [5:0] c;
      c = up ? a[5:0] + 6'd1 : a[5:0] - 6'd1;
      return cg ? {1'b0, c} : dd_step(a, up);
   endfunction

   function automatic logic [5:0] off_step(input logic [5:0] o, input logic up);
      if (up) return (o == 6'd39) ? 6'd0 : o + 6'd1;
      return (o == 6'd0) ? 6'd39 : o - 6'd1;
   endfunction

   logic [7:0] ddram [0:79];
   logic [7:0] cgram [0:63];

   logic   en_s1_q, en_s2_q, en_q;
   bus_t   bus_s1_q, bus_s2_q, bus_q;
   state_e state_q, state_d;
   logic   init_q, init_d;
   logic [6:0] clr_idx_q, clr_idx_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic   txn_valid_q, txn_valid_d, txn_rs_q, txn_rs_d, txn_rw_q, txn_rw_d;
   logic [7:0] txn_data_q, txn_data_d;
   logic [6:0] ac_q, ac_d;
   logic   cgram_sel_q, cgram_sel_d;
   ctrl_t  ctrl_q, ctrl_d;
   logic [5:0] shift_off_q, shift_off_d;
   logic [2:0] err_q, err_d;
   logic [7:0] rd_data_q, rd_data_d;

   logic       fall, live, dd_we, cg_we;
   logic [6:0] dd_waddr;
   logic [7:0] dd_wdata;
   logic [5:0] cg_waddr;

   assign fall = en_q & ~en_s2_q;
   assign live = fall & (~bus_q.rw | READ_EN);

   // NOTE: combinational blocks use blocking '=' with every output defaulted first, so no latches infer.
   always_comb begin
      state_d     = state_q;
      init_d      = init_q;
      clr_idx_d   = clr_idx_q;
      hold_cnt_d  = hold_cnt_q;
      txn_valid_d = 1'b0;
      txn_rs_d    = txn_rs_q;
      txn_rw_d    = txn_rw_q;
      txn_data_d  = txn_data_q;
      ac_d        = ac_q;
      cgram_sel_d = cgram_sel_q;
      ctrl_d      = ctrl_q;
      shift_off_d = shift_off_q;
      err_d       = err_q;
      dd_we       = 1'b0;
      dd_waddr    = clr_idx_q;
      dd_wdata    = DDRAM_RESET;
      cg_we       = 1'b0;
      cg_waddr    = ac_q[5:0];

      if (live && state_q != S_IDLE) err_d[0] = 1'b1;

      unique case (state_q)
         S_IDLE: begin
            if (init_q) begin
               init_d    = 1'b0;
               clr_idx_d = 7'd0;
               state_d   = S_CLEAR;
            end else if (live) begin
               txn_valid_d = 1'b1;
               txn_rs_d    = bus_q.rs;
               txn_rw_d    = bus_q.rw;
               txn_data_d  = bus_q.data;
               state_d     = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_HOLD;
            if (txn_rw_q) begin
               if (txn_rs_q) ac_d = ac_step(ac_q, cgram_sel_q, ctrl_q.inc_mode);
            end else if (!txn_rs_q) begin
               casez (txn_data_q)
                  8'b1???????: begin ac_d = txn_data_q[6:0]; cgram_sel_d = 1'b0; end
                  8'b01??????: begin ac_d = {1'b0, txn_data_q[5:0]}; cgram_sel_d = 1'b1; end
                  8'b001?????: begin
                     ctrl_d.mode8  = txn_data_q[4];
                     ctrl_d.lines2 = txn_data_q[3];
                     if (!txn_data_q[4]) err_d[1] = 1'b1;
                  end
                  8'b0001????: begin
                     if (txn_data_q[3]) shift_off_d = off_step(shift_off_q, txn_data_q[2]);
                     else               ac_d = ac_step(ac_q, cgram_sel_q, txn_data_q[2]);
                  end
                  8'b00001???: {ctrl_d.display_on, ctrl_d.cursor_on, ctrl_d.blink_on} = txn_data_q[2:0];
                  8'b000001??: {ctrl_d.inc_mode, ctrl_d.shift_mode} = txn_data_q[1:0];
                  8'b0000001?: begin ac_d = 7'd0; cgram_sel_d = 1'b0; shift_off_d = 6'd0; end
                  8'b00000001: begin
                     ac_d            = 7'd0;
                     cgram_sel_d     = 1'b0;
                     shift_off_d     = 6'd0;
                     ctrl_d.inc_mode = 1'b1;
                     clr_idx_d       = 7'd0;
                     state_d         = S_CLEAR;
                  end
                  default: ;
               endcase
            end else if (cgram_sel_q) begin
               cg_we = 1'b1;
               ac_d  = ac_step(ac_q, 1'b1, ctrl_q.inc_mode);
            end else begin
               if (dd_valid(ac_q)) begin
                  dd_we    = 1'b1;
                  dd_waddr = dd_index(ac_q);
                  dd_wdata = txn_data_q;
               end else begin
                  err_d[2] = 1'b1;
               end
               ac_d = dd_step(ac_q, ctrl_q.inc_mode);
               if (ctrl_q.shift_mode) shift_off_d = off_step(shift_off_q, ctrl_q.inc_mode);
            end
         end
         S_CLEAR: begin
            dd_we     = 1'b1;
            clr_idx_d = clr_idx_q + 7'd1;
            if (clr_idx_q == 7'd79) state_d = S_HOLD;
         end
         S_HOLD: begin
            if (hold_cnt_q == 8'(BUSY_CYCLES - 1)) begin
               hold_cnt_d = 8'd0;
               state_d    = S_IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
      endcase
   end

   always_comb begin
      if (rd_cgram)               rd_data_d = cgram[rd_addr[5:0]];
      else if (dd_valid(rd_addr)) rd_data_d = ddram[dd_index(rd_addr)];
      else                        rd_data_d = 8'h20;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_s1_q     <= 1'b0;
         en_s2_q     <= 1'b0;
         en_q        <= 1'b0;
         bus_s1_q    <= '0;
         bus_s2_q    <= '0;
         bus_q       <= '0;
         state_q     <= S_IDLE;
         init_q      <= 1'b1;
         clr_idx_q   <= 7'd0;
         hold_cnt_q  <= 8'd0;
         txn_valid_q <= 1'b0;
         txn_rs_q    <= 1'b0;
         txn_rw_q    <= 1'b0;
         txn_data_q  <= 8'd0;
         ac_q        <= 7'd0;
         cgram_sel_q <= 1'b0;
         ctrl_q      <= '0;
         shift_off_q <= 6'd0;
         err_q       <= 3'd0;
         rd_data_q   <= 8'd0;
      end else begin
         en_s1_q     <= enable;
         en_s2_q     <= en_s1_q;
         en_q        <= en_s2_q;
         bus_s1_q    <= '{rs: rs, rw: rw, data: data};
         bus_s2_q    <= bus_s1_q;
         bus_q       <= bus_s2_q;
         state_q     <= state_d;
         init_q      <= init_d;
         clr_idx_q   <= clr_idx_d;
         hold_cnt_q  <= hold_cnt_d;
         txn_valid_q <= txn_valid_d;
         txn_rs_q    <= txn_rs_d;
         txn_rw_q    <= txn_rw_d;
         txn_data_q  <= txn_data_d;
         ac_q        <= ac_d;
         cgram_sel_q <= cgram_sel_d;
         ctrl_q      <= ctrl_d;
         shift_off_q <= shift_off_d;
         err_q       <= err_d;
         rd_data_q   <= rd_data_d;
      end
   end

   // NOTE: the RAMs have no reset; DDRAM is filled by the post-reset sweep, CGRAM keeps its contents.
   always_ff @(posedge clk) begin
      if (dd_we) ddram[dd_waddr] <= dd_wdata;
      if (cg_we) cgram[cg_waddr] <= txn_data_q;
   end

`ifdef LCD_RESPONDER_READ_EN
   logic [7:0] ac_byte;
   always_comb begin
      if (cgram_sel_q)         ac_byte = cgram[ac_q[5:0]];
      else if (dd_valid(ac_q)) ac_byte = ddram[dd_index(ac_q)];
      else                     ac_byte = 8'h20;
   end
   assign rd_bus_oe   = en_s2_q & bus_s2_q.rw;
   assign rd_bus_data = bus_s2_q.rs ? ac_byte : {busy, ac_q};
`endif

   assign rd_data      = rd_data_q;
   assign busy         = (state_q != S_IDLE);
   assign txn_valid    = txn_valid_q;
   assign txn_rs       = txn_rs_q;
   assign txn_data     = txn_data_q;
   assign addr_counter = ac_q;
   assign cgram_sel    = cgram_sel_q;
   assign display_on   = ctrl_q.display_on;
   assign cursor_on    = ctrl_q.cursor_on;
   assign blink_on     = ctrl_q.blink_on;
   assign inc_mode     = ctrl_q.inc_mode;
   assign shift_mode   = ctrl_q.shift_mode;
   assign lines2       = ctrl_q.lines2;
   assign mode8        = ctrl_q.mode8;
   assign shift_off    = shift_off_q;
   assign err_flags    = err_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed self-checking bench for lcd_bus_responder: reset fill, commands, CGRAM/DDRAM writes,
// DDRAM wrap, invalid-address and overrun errors, and reset in the middle of a clear sweep.
module tb_lcd_bus_responder;
   logic       clk = 1'b0;
   logic       reset, rs, rw, enable, rd_cgram;
   logic [7:0] data;
   logic [6:0] rd_addr;
   logic [7:0] rd_data, txn_data;
   logic       busy, txn_valid, txn_rs, cgram_sel;
   logic [6:0] addr_counter;
   logic       display_on, cursor_on, blink_on, inc_mode, shift_mode, lines2, mode8;
   logic [5:0] shift_off;
   logic [2:0] err_flags;
`ifdef LCD_RESPONDER_READ_EN
   logic [7:0] rd_bus_data;
   logic       rd_bus_oe;
`endif

   int checks = 0;
   int failures = 0;
   int txn_cnt = 0;
   int n;
   int t0;

   always #5 clk = ~clk;

   lcd_bus_responder #(.BUSY_CYCLES(4), .DDRAM_RESET(8'h20)) dut (
      .clk(clk), .reset(reset), .rs(rs), .rw(rw), .enable(enable), .data(data),
      .rd_addr(rd_addr), .rd_cgram(rd_cgram), .rd_data(rd_data), .busy(busy),
      .txn_valid(txn_valid), .txn_rs(txn_rs), .txn_data(txn_data),
      .addr_counter(addr_counter), .cgram_sel(cgram_sel),
      .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
      .inc_mode(inc_mode), .shift_mode(shift_mode), .lines2(lines2), .mode8(mode8),
      .shift_off(shift_off), .err_flags(err_flags)
`ifdef LCD_RESPONDER_READ_EN
      , .rd_bus_data(rd_bus_data), .rd_bus_oe(rd_bus_oe)
`endif
   );

   always @(negedge clk) if (txn_valid) txn_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic strobe(input logic r, input logic [7:0] d);
      @(negedge clk);
      rs = r; rw = 1'b0; data = d; enable = 1'b1;
      repeat (8) @(negedge clk);
      enable = 1'b0;
   endtask

   // Counts busy cycles until busy drops; a missing or endless busy pulse is a failure.
   task automatic wait_idle(output int cycles);
      cycles = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (busy) cycles++;
         else if (cycles > 0 || i > 20) break;
      end
      check("wait_idle_done", {31'd0, (cycles != 0) && !busy}, 1);
   endtask

   task automatic rd_check(input string tag, input logic cg, input logic [6:0] a, input logic [7:0] exp);
      @(negedge clk);
      rd_cgram = cg; rd_addr = a;
      @(negedge clk);
      check(tag, {24'd0, rd_data}, {24'd0, exp});
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; rs = 1'b0; rw = 1'b0; enable = 1'b0; data = 8'h00;
      rd_addr = 7'h00; rd_cgram = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_rd_data", {24'd0, rd_data}, 0);
      check("rst_addr", {25'd0, addr_counter}, 0);
      check("rst_err", {29'd0, err_flags}, 0);

      // Reset fill: 80 sweep cycles plus 4 hold cycles.
      reset = 1'b1;
      wait_idle(n);
      check("fill_busy_cycles", n, 84);
      rd_check("fill_0x00", 1'b0, 7'h00, 8'h20);
      rd_check("fill_0x27", 1'b0, 7'h27, 8'h20);
      rd_check("fill_0x40", 1'b0, 7'h40, 8'h20);
      rd_check("fill_0x67", 1'b0, 7'h67, 8'h20);
      check("fill_err", {29'd0, err_flags}, 0);

      // Function set, display control, clear.
      strobe(1'b0, 8'h38); wait_idle(n);
      check("cmd_busy_cycles", n, 5);
      strobe(1'b0, 8'h0C); wait_idle(n);
      strobe(1'b0, 8'h01); wait_idle(n);
      check("clear_busy_cycles", n, 85);
      check("mode8", {31'd0, mode8}, 1);
      check("lines2", {31'd0, lines2}, 1);
      check("display_on", {31'd0, display_on}, 1);
      check("cursor_blink", {30'd0, cursor_on, blink_on}, 0);
      check("clear_inc_mode", {31'd0, inc_mode}, 1);
      check("txn_count3", txn_cnt, 3);
      check("txn_last", {23'd0, txn_rs, txn_data}, {23'd0, 1'b0, 8'h01});

      // CGRAM glyph upload.
      strobe(1'b0, 8'h48); wait_idle(n);
      strobe(1'b1, 8'h0E); wait_idle(n);
      strobe(1'b1, 8'h11); wait_idle(n);
      strobe(1'b1, 8'h1F); wait_idle(n);
      check("cg_addr", {24'd0, cgram_sel, addr_counter}, {24'd0, 1'b1, 7'h0B});
      check("txn_rs_data", {31'd0, txn_rs}, 1);
      rd_check("cg_8", 1'b1, 7'h08, 8'h0E);
      rd_check("cg_9", 1'b1, 7'h09, 8'h11);
      rd_check("cg_10", 1'b1, 7'h0A, 8'h1F);

      // DDRAM line-end wrap and invalid-address write.
      strobe(1'b0, 8'hA7); wait_idle(n);
      check("dd_set_addr", {24'd0, cgram_sel, addr_counter}, {24'd0, 1'b0, 7'h27});
      strobe(1'b1, 8'h41); wait_idle(n);
      strobe(1'b1, 8'h42); wait_idle(n);
      check("dd_wrap_addr", {25'd0, addr_counter}, 7'h41);
      rd_check("dd_0x27", 1'b0, 7'h27, 8'h41);
      rd_check("dd_0x40", 1'b0, 7'h40, 8'h42);
      strobe(1'b0, 8'hA8); wait_idle(n);
      strobe(1'b1, 8'h43); wait_idle(n);
      check("bad_addr_err", {29'd0, err_flags}, 3'b100);
      check("bad_addr_step", {25'd0, addr_counter}, 7'h29);
      rd_check("bad_addr_read", 1'b0, 7'h28, 8'h20);
      rd_check("dd_0x41_untouched", 1'b0, 7'h41, 8'h20);

      // Overrun: 0x80 strobed while the clear sweep runs.
      t0 = txn_cnt;
      strobe(1'b0, 8'h01);
      repeat (2) @(negedge clk);
      strobe(1'b0, 8'h80);
      wait_idle(n);
      check("overrun_err", {29'd0, err_flags}, 3'b101);
      check("overrun_txn_data", {24'd0, txn_data}, 8'h01);
      check("overrun_txn_count", txn_cnt - t0, 1);
      check("overrun_addr", {24'd0, cgram_sel, addr_counter}, 0);
      rd_check("cleared_0x27", 1'b0, 7'h27, 8'h20);

      // Decrement mode, wrap down, display shift, 4-bit request.
      strobe(1'b0, 8'h04); wait_idle(n);
      strobe(1'b0, 8'h80); wait_idle(n);
      strobe(1'b1, 8'h58); wait_idle(n);
      check("dec_wrap_addr", {25'd0, addr_counter}, 7'h67);
      rd_check("dd_0x00_X", 1'b0, 7'h00, 8'h58);
      strobe(1'b0, 8'h18); wait_idle(n);
      check("shift_off_wrap", {26'd0, shift_off}, 39);
      strobe(1'b0, 8'h14); wait_idle(n);
      check("shift_cursor_wrap", {25'd0, addr_counter}, 7'h00);
      strobe(1'b0, 8'h28); wait_idle(n);
      check("fn_4bit", {29'd0, err_flags}, 3'b111);
      check("fn_4bit_flags", {30'd0, mode8, lines2}, 2'b01);

      // Reset in the middle of a clear sweep.
      strobe(1'b0, 8'h01);
      repeat (20) @(negedge clk);
      reset = 1'b0;
      #1;
      check("midclr_busy", {31'd0, busy}, 0);
      check("midclr_flags", {24'd0, display_on, cursor_on, blink_on, inc_mode, shift_mode, lines2, mode8, cgram_sel}, 0);
      check("midclr_counters", {19'd0, addr_counter, shift_off}, 0);
      check("midclr_err", {29'd0, err_flags}, 0);
      check("midclr_rd_txn", {23'd0, rd_data, txn_valid}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      wait_idle(n);
      check("refill_busy_cycles", n, 84);
      rd_check("refill_0x00", 1'b0, 7'h00, 8'h20);
      rd_check("refill_0x67", 1'b0, 7'h67, 8'h20);
      rd_check("cg_kept", 1'b1, 7'h08, 8'h0E);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
- Behavioural-RTL responder for the HD44780-style 8-bit parallel LCD bus that our display driver writes (rs, rw, enable, data).
- Decodes each enable-strobed transaction, maintains DDRAM (2x40), CGRAM (8x8) and the display control flags, and exposes a read-back port.
- Sits on the receiving end of the driver, either in the testbench or on-chip as a display mirror and checker, so that glyph uploads and cursor writes can be verified without a physical panel.

Parameters:
- BUSY_CYCLES, 4: clk cycles busy is held after any accepted transaction, and after the clear sweep finishes.
- DDRAM_RESET, 8'h20: fill value used by reset and by the Clear Display command.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rs  in  1  register select (0 = command, 1 = data).
- rw  in  1  read/write (0 = write).
- enable  in  1  bus strobe, asynchronous to clk; a transaction is latched on its falling edge.
- data  in  8  bus data.
- rd_addr  in  7  read-back address (DDRAM address format, or CGRAM address in bits [5:0]).
- rd_cgram  in  1  read-back source select (1 = CGRAM).
- rd_data  out  8  registered read-back data.
- busy  out  1  busy flag.
- txn_valid  out  1  one-cycle pulse per accepted transaction.
- txn_rs  out  1  rs of the last accepted transaction.
- txn_data  out  8  data of the last accepted transaction.
- addr_counter  out  7  current address counter.
- cgram_sel  out  1  1 = address counter points into CGRAM.
- display_on, cursor_on, blink_on  out  1 each  display control flags.
- inc_mode, shift_mode  out  1 each  entry-mode flags.
- lines2, mode8  out  1 each  function-set flags.
- shift_off  out  6  display shift offset, 0..39.
- err_flags  out  3  sticky error flags: [0] overrun, [1] 4-bit mode requested, [2] DDRAM write to an invalid address.

Behaviour:
- Reset (asynchronous, reset=0): all flags and counters go to 0 and busy=0; rd_data=0; DDRAM fills with DDRAM_RESET over the first 80 clks after reset release, with busy=1 during the fill; CGRAM is not cleared.
- Input capture: enable, rs, rw and data pass through the same 2-stage synchronizer, so they stay aligned.
  - fall = en_q & ~en_s2.
  - The transaction executes on the clk edge after fall is detected.
  - txn_valid pulses that cycle.
  - State updates are visible 3 clk edges after the first edge that samples enable=0.
- A transaction arriving while busy=1 is ignored: no state change, no txn_valid, err_flags[0] set.
- rw=1 transactions: no state change and txn_valid=0, unless the optional feature is enabled.
- Command decode (rs=0), highest set bit wins:
  - 1xxxxxxx Set DDRAM address: addr_counter=data[6:0], cgram_sel=0.
  - 01xxxxxx Set CGRAM address: addr_counter={1'b0, data[5:0]}, cgram_sel=1.
  - 001DNxxx Function set: mode8=D, lines2=N; err_flags[1] set if D=0. Data is still decoded as 8-bit.
  - 0001SRxx Shift:
    - S=0 moves addr_counter by +1 (R=1) or -1, with DDRAM wrap.
    - S=1 moves shift_off by +1 (R=1) or -1, modulo 40.
  - 00001DCB Display control: display_on=D, cursor_on=C, blink_on=B.
  - 000001IS Entry mode: inc_mode=I, shift_mode=S.
  - 0000001x Return home: addr_counter=0, cgram_sel=0, shift_off=0.
  - 00000001 Clear display, run by the FSM below; also sets addr_counter=0, cgram_sel=0, shift_off=0, inc_mode=1.
  - 00000000: no operation, but still makes the block busy.
- Data write (rs=1), by target:
  - CGRAM: writes CGRAM[addr_counter[5:0]]; the address steps ±1 modulo 64.
  - DDRAM: valid ranges are 0x00-0x27 (index 0-39) and 0x40-0x67 (index 40-79).
    - Wrap going up: 0x27 -> 0x40, 0x67 -> 0x00.
    - Wrap going down: 0x00 -> 0x67, 0x40 -> 0x27.
    - A write to an invalid address is dropped and sets err_flags[2]; the address still steps +1/-1 (7-bit wrap).
    - If shift_mode=1, each DDRAM write also steps shift_off in the inc_mode direction.
- FSM states: IDLE, EXEC, CLEAR, HOLD.
  - IDLE -> EXEC on fall.
  - EXEC: performs the decode. Goes to CLEAR for command 0x01, otherwise to HOLD.
  - CLEAR: writes DDRAM_RESET to index 0..79, one per clk, then goes to HOLD.
  - HOLD: counts BUSY_CYCLES, then goes to IDLE.
  - busy = (state != IDLE).
- Read-back: rd_data is registered 1 clk after rd_addr/rd_cgram. An invalid DDRAM address reads 8'h20. The read port is independent of busy; a read of the cell being written on the same edge returns the old value.
- Simultaneous events: a fall detected in the same cycle busy deasserts counts as overrun, because busy is evaluated on the registered state.
- Reset mid-CLEAR: aborts the sweep and restarts the reset fill.

Optional Feature:
- Macro: LCD_RESPONDER_READ_EN.
- When defined:
  - Adds ports rd_bus_data (out, 8) and rd_bus_oe (out, 1).
  - While the synchronized enable=1 and rw=1, rd_bus_oe=1 and rd_bus_data is:
    - {busy, addr_counter} when rs=0;
    - the RAM byte at addr_counter when rs=1. The address then steps on the falling edge, and txn_valid pulses.
- When undefined: those ports are absent, and rw=1 transactions are ignored silently.

Test Plan:
- Reset release, then wait 100 clk -> busy low by clk ~85; rd_addr=0x00, 0x27, 0x40 and 0x67 each read 8'h20; err_flags=0.
- Strobe cmds 0x38, 0x0C, 0x01 (enable period 40 clk) -> mode8=1, lines2=1, display_on=1, cursor_on=0; busy held 80+4 clk after the 0x01; DDRAM all 0x20.
- Strobe 0x48, then rs=1 bytes 0x0E, 0x11, 0x1F -> CGRAM[8..10]=0E,11,1F; addr_counter=0x0B, cgram_sel=1.
- Strobe 0xA7 (addr 0x27), then data 0x41, 0x42 -> DDRAM 0x27='A', 0x40='B'; addr_counter=0x41. Then 0xA8 plus data 0x43 -> write dropped, err_flags[2]=1.
- Strobe 0x01 immediately followed by 0x80 within 20 clk -> 0x80 ignored; err_flags[0]=1; addr_counter stays 0.
- Strobe 0x04, then 0x80+0x00 and data 0x58 -> DDRAM 0x00='X' and addr_counter=0x67 (decrement wrap). Assert reset mid-CLEAR -> all outputs zero immediately, fill restarts.
